// File: rtl/dpram_sync_rd_param.sv
// dpram_sync_rd_param: dual-port RAM (A read/write, B read-only) with synchronous read,
// configurable latency and read-during-write mode, plus a clear sweep after reset or on request.
module dpram_sync_rd_param #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1,
    parameter int RDW_MODE = 0,
    parameter int CLR_ON_RST = 1,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] di,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] dpra,
    input  logic              clr_req,
    output logic [DATA_W-1:0] spo,
    output logic              spo_vld,
    output logic [DATA_W-1:0] dpo,
    output logic              dpo_vld,
    output logic              busy
);
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(2**ADDR_W - 1);
    typedef enum logic {READY, CLEAR} state_t;
    state_t state, state_nx;
    logic [ADDR_W:0] cnt, cnt_nx;
    logic [DATA_W-1:0] ram [2**ADDR_W];
    logic wr_usr, wr_en, acc_a, acc_b, v_a, v_b;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data, rd_a, rd_b, q_a, q_b;

    assign busy = state == CLEAR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLR_ON_RST != 0 ? CLEAR : READY;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        if (busy) begin
            cnt_nx = cnt + 1'b1;
            if (cnt == LAST) state_nx = READY;
        end else if (clr_req) begin
            state_nx = CLEAR;
            cnt_nx = '0;
        end
    end

    assign wr_usr = !busy && we;
    assign acc_a = !busy && re_a;
    assign acc_b = !busy && re_b;
    assign wr_en = !rst && (busy || we);
    assign wr_addr = busy ? cnt[ADDR_W-1:0] : a;
    assign wr_data = busy ? CLR_VAL : di;

    always_ff @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= wr_data;
    end

    // write-first bypasses the incoming word; read-first sees the array before this edge's write
    assign rd_a = (RDW_MODE == 0 && wr_usr) ? di : ram[a];
    assign rd_b = (RDW_MODE == 0 && wr_usr && a == dpra) ? di : ram[dpra];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_a <= '0;
            q_b <= '0;
            v_a <= 1'b0;
            v_b <= 1'b0;
        end else begin
            v_a <= acc_a;
            v_b <= acc_b;
            if (acc_a) q_a <= rd_a;
            if (acc_b) q_b <= rd_b;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    spo <= '0;
                    dpo <= '0;
                    spo_vld <= 1'b0;
                    dpo_vld <= 1'b0;
                end else begin
                    spo_vld <= v_a;
                    dpo_vld <= v_b;
                    if (v_a) spo <= q_a;
                    if (v_b) dpo <= q_b;
                end
            end
        end else begin : g_lat1
            assign spo = q_a;
            assign dpo = q_b;
            assign spo_vld = v_a;
            assign dpo_vld = v_b;
        end
    endgenerate
endmodule

// File: tb/tb_dpram_sync_rd_param.sv
// tb_dpram_sync_rd_param: scoreboard bench driving a write-first/latency-1 and a
// read-first/latency-2 instance with the same stimulus.
module tb_dpram_sync_rd_param;
    localparam int DW = 18, AW = 6, N = 64;
    typedef struct {logic [DW-1:0] d; int t;} exp_t;

    logic clk = 0, rst = 1, we = 0, re_a = 0, re_b = 0, clr_req = 0;
    logic [AW-1:0] a = 0, dpra = 0;
    logic [DW-1:0] di = 0;
    logic [DW-1:0] spo0, dpo0, spo1, dpo1;
    logic sv0, dv0, sv1, dv1, busy0, busy1;

    int cyc = 0, pass_n = 0, tot_n = 0, n;
    exp_t q[4][$];
    logic [DW-1:0] last[4];
    logic [DW-1:0] mem[N];
    logic mbusy = 1;
    int mcnt = 0;

    dpram_sync_rd_param #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .we(we), .re_a(re_a), .a(a), .di(di), .re_b(re_b), .dpra(dpra),
        .clr_req(clr_req), .spo(spo0), .spo_vld(sv0), .dpo(dpo0), .dpo_vld(dv0), .busy(busy0));
    dpram_sync_rd_param #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .we(we), .re_a(re_a), .a(a), .di(di), .re_b(re_b), .dpra(dpra),
        .clr_req(clr_req), .spo(spo1), .spo_vld(sv1), .dpo(dpo1), .dpo_vld(dv1), .busy(busy1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // monitor: pop on every valid strobe, otherwise the output must hold its last value
    always @(negedge clk) begin
        logic [DW-1:0] d[4];
        logic v[4];
        exp_t e;
        d = '{spo0, dpo0, spo1, dpo1};
        v = '{sv0, dv0, sv1, dv1};
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                chk($sformatf("rst_out%0d", i), {45'd0, v[i], d[i]}, 64'd0);
                last[i] = '0;
            end else if (v[i]) begin
                if (q[i].size() == 0) chk($sformatf("unexpected_vld%0d", i), 64'd1, 64'd0);
                else begin
                    e = q[i].pop_front();
                    chk($sformatf("rd%0d_data", i), d[i], e.d);
                    chk($sformatf("rd%0d_lat", i), cyc, e.t);
                end
                last[i] = d[i];
            end else chk($sformatf("hold%0d", i), d[i], last[i]);
        end
    end

    task automatic step(input logic w, input logic [AW-1:0] aa, input logic [DW-1:0] dd,
                        input logic ra, input logic rb, input logic [AW-1:0] pa,
                        input logic cl, input logic r);
        we = w; a = aa; di = dd; re_a = ra; re_b = rb; dpra = pa; clr_req = cl; rst = r;
        if (r) begin
            for (int i = 0; i < 4; i++) q[i].delete();
            mbusy = 1;
            mcnt = 0;
        end else if (!mbusy) begin
            if (ra) begin
                q[0].push_back('{w ? dd : mem[aa], cyc + 1});
                q[2].push_back('{mem[aa], cyc + 2});
            end
            if (rb) begin
                q[1].push_back('{(w && aa == pa) ? dd : mem[pa], cyc + 1});
                q[3].push_back('{mem[pa], cyc + 2});
            end
            if (w) mem[aa] = dd;
            if (cl) begin
                mbusy = 1;
                mcnt = 0;
            end
        end else begin
            mem[mcnt] = '0;
            mbusy = mcnt != N - 1;
            mcnt++;
        end
        @(posedge clk);
        #1;
        chk("busy0", busy0, mbusy);
        chk("busy1", busy1, mbusy);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sweep_wait(input string nm, input int want);
        n = 0;
        while (busy0 && n < 200) begin
            idle();
            n++;
        end
        chk(nm, n, want);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        sweep_wait("sweep_len_rst", N);
        for (int i = 0; i < N; i++) step(0, AW'(i), 0, 1, 1, AW'(N - 1 - i), 0, 0);
        repeat (3) idle();
        step(1, 5, 18'h2A5A5, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 5, 0, 0);
        idle();
        step(1, 9, 18'h00111, 0, 0, 0, 0, 0);
        step(1, 9, 18'h3FFFF, 1, 1, 9, 0, 0);
        step(0, 0, 0, 0, 1, 9, 0, 0);
        step(1, 7, 18'h1ABCD, 1, 1, 9, 0, 0);
        step(0, 0, 0, 1, 1, 7, 0, 0);
        step(0, 0, 0, 1, 1, 5, 1, 0);
        step(1, 3, 18'h12345, 1, 1, 3, 1, 0);
        sweep_wait("sweep_len_req", N - 1);
        step(0, 3, 0, 1, 1, 5, 0, 0);
        step(0, 9, 0, 1, 1, 7, 0, 0);
        step(1, 12, 18'h0F0F0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (30) idle();
        chk("mid_sweep", busy0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        sweep_wait("sweep_len_abort", N);
        step(0, 12, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), 1, 1, AW'($urandom), 0, 0);
        repeat (4) idle();
        for (int i = 0; i < 4; i++) chk($sformatf("drain%0d", i), q[i].size(), 0);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
